// File: rtl/regfile_sp_param.sv
// Parameterised register file with one register doubling as a stack pointer.
// Push/pop adjust SP in place; wraparound raises sticky overflow/underflow flags.
module regfile_sp_param #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 2,
  parameter int                SP_IDX   = (1 << ADDR_W) - 1,
  parameter logic [DATA_W-1:0] SP_RESET = '1,
  parameter int                BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] rw_addr,
  input  logic [DATA_W-1:0] wd,
  input  logic              inc_sp,
  input  logic              dec_sp,
  input  logic              clr_flags,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_ovf,
  output logic              sp_unf
);

  localparam int                NREGS   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic              sp_ovf_reg;
  logic              sp_unf_reg;
  logic [DATA_W-1:0] sp_cur;
  logic [DATA_W-1:0] sp_next;
  logic              ovf_set;
  logic              unf_set;
  logic              sp_write;
  logic [NREGS-1:0]  wr_hit;

  assign sp_cur   = regs_reg[SP_ADDR];
  assign sp_write = we && (rw_addr == SP_ADDR);

  // The SP register is excluded here; its next value comes from sp_next.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_hit
      if (gi == SP_IDX) begin : g_sp
        assign wr_hit[gi] = 1'b0;
      end else begin : g_gp
        assign wr_hit[gi] = we && (rw_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // An explicit SP write beats push, and push beats pop.
  always_comb begin
    sp_next = sp_cur;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (sp_write) begin
      sp_next = wd;
    end else if (dec_sp) begin
      sp_next = sp_cur - DATA_W'(1);
      ovf_set = (sp_cur == '0);
    end else if (inc_sp) begin
      sp_next = sp_cur + DATA_W'(1);
      unf_set = (sp_cur == '1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == SP_IDX) begin
          regs_reg[i] <= sp_next;
        end else if (wr_hit[i]) begin
          regs_reg[i] <= wd;
        end
      end
    end
  end

  // Set has priority over clear so a wrap in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_ovf_reg <= 1'b0;
      sp_unf_reg <= 1'b0;
    end else begin
      sp_ovf_reg <= ovf_set || (sp_ovf_reg && !clr_flags);
      sp_unf_reg <= unf_set || (sp_unf_reg && !clr_flags);
    end
  end

  // Forwarding covers wd only; sp_out always shows the stored SP.
  always_comb begin
    rd_a = regs_reg[ra_addr];
    rd_b = regs_reg[rb_addr];
    if ((BYPASS != 0) && we && (rw_addr == ra_addr)) rd_a = wd;
    if ((BYPASS != 0) && we && (rw_addr == rb_addr)) rd_b = wd;
  end

  assign sp_out = sp_cur;
  assign sp_ovf = sp_ovf_reg;
  assign sp_unf = sp_unf_reg;

endmodule

// File: tb/tb_regfile_sp_param.sv
// Bench for regfile_sp_param: directed vector table, a push/wrap sequence and
// randomized traffic against an array-based model. A BYPASS=0 copy shares inputs.
module tb_regfile_sp_param;

  logic       clk = 1'b0;
  logic       rst_n, we, inc_sp, dec_sp, clr_flags;
  logic [1:0] rw_addr, ra_addr, rb_addr;
  logic [7:0] wd;
  logic [7:0] rd_a, rd_b, sp_out, rd_a0, rd_b0, sp_out0;
  logic       sp_ovf, sp_unf, sp_ovf0, sp_unf0;

  int total = 0;
  int bad   = 0;

  int mdl [4];
  bit m_ovf, m_unf;

  always #5 clk = ~clk;

  regfile_sp_param #(.DATA_W(8), .ADDR_W(2), .SP_IDX(3), .SP_RESET(8'hFF), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .rw_addr(rw_addr), .wd(wd),
    .inc_sp(inc_sp), .dec_sp(dec_sp), .clr_flags(clr_flags),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_a(rd_a), .rd_b(rd_b),
    .sp_out(sp_out), .sp_ovf(sp_ovf), .sp_unf(sp_unf)
  );

  regfile_sp_param #(.DATA_W(8), .ADDR_W(2), .SP_IDX(3), .SP_RESET(8'hFF), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .rw_addr(rw_addr), .wd(wd),
    .inc_sp(inc_sp), .dec_sp(dec_sp), .clr_flags(clr_flags),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_a(rd_a0), .rd_b(rd_b0),
    .sp_out(sp_out0), .sp_ovf(sp_ovf0), .sp_unf(sp_unf0)
  );

  typedef struct {
    logic       rst_n, we;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       inc, dec, clr;
    logic [1:0] ra, rb;
    logic [7:0] a, b, a0, b0, sp;
    logic       ovf, unf;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic r, input logic w, input logic [1:0] ad, input logic [7:0] d,
                       input logic i, input logic dc, input logic c,
                       input logic [1:0] a, input logic [1:0] b);
    @(negedge clk);
    rst_n = r; we = w; rw_addr = ad; wd = d;
    inc_sp = i; dec_sp = dc; clr_flags = c; ra_addr = a; rb_addr = b;
    #1;
  endtask

  // Advance one rising edge and update the model from the applied inputs.
  task automatic tick();
    int  sp;
    bit  os, us;
    @(posedge clk);
    if (!rst_n) begin
      mdl = '{0, 0, 0, 255};
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      sp = mdl[3];
      os = 1'b0;
      us = 1'b0;
      if (we && rw_addr == 2'd3) sp = int'(wd);
      else if (dec_sp) begin os = (sp == 0);   sp = (sp + 255) % 256; end
      else if (inc_sp) begin us = (sp == 255); sp = (sp + 1) % 256;   end
      if (we && rw_addr != 2'd3) mdl[rw_addr] = int'(wd);
      mdl[3] = sp;
      m_ovf = os || (m_ovf && !clr_flags);
      m_unf = us || (m_unf && !clr_flags);
    end
  endtask

  task automatic chk_model(input int n);
    logic [7:0] ea, eb;
    ea = (we && rw_addr == ra_addr) ? 8'(wd) : 8'(mdl[ra_addr]);
    eb = (we && rw_addr == rb_addr) ? 8'(wd) : 8'(mdl[rb_addr]);
    chk($sformatf("rnd%0d rd_a", n), rd_a, ea);
    chk($sformatf("rnd%0d rd_b", n), rd_b, eb);
    chk($sformatf("rnd%0d rd_a nobyp", n), rd_a0, 8'(mdl[ra_addr]));
    chk($sformatf("rnd%0d rd_b nobyp", n), rd_b0, 8'(mdl[rb_addr]));
    chk($sformatf("rnd%0d sp_out", n), sp_out, 8'(mdl[3]));
    chk($sformatf("rnd%0d sp_out nobyp", n), sp_out0, 8'(mdl[3]));
    chk($sformatf("rnd%0d sp_ovf", n), {7'd0, sp_ovf}, {7'd0, m_ovf});
    chk($sformatf("rnd%0d sp_unf", n), {7'd0, sp_unf}, {7'd0, m_unf});
  endtask

  initial begin
    logic       r, w, i, dc, c;
    logic [1:0] ad, a, b;
    logic [7:0] d;

    //          rst we ad wd     in dc cl ra b  | a      b      a0     b0     sp     ovf unf
    vecs[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h00, 0, 0, 0, 2, 3, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 0, 0};
    vecs[2]  = '{1, 1, 0, 8'h11, 0, 0, 0, 0, 0, 8'h11, 8'h11, 8'h00, 8'h00, 8'hFF, 0, 0};
    vecs[3]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h11, 8'h00, 8'h11, 8'h00, 8'hFF, 0, 0};
    vecs[4]  = '{1, 1, 3, 8'h01, 0, 0, 0, 3, 0, 8'h01, 8'h11, 8'hFF, 8'h11, 8'hFF, 0, 0};
    vecs[5]  = '{1, 0, 0, 8'h00, 0, 1, 0, 3, 3, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 0, 0};
    vecs[6]  = '{1, 0, 0, 8'h00, 0, 1, 0, 3, 0, 8'h00, 8'h11, 8'h00, 8'h11, 8'h00, 0, 0};
    vecs[7]  = '{1, 0, 0, 8'h00, 0, 0, 1, 3, 0, 8'hFF, 8'h11, 8'hFF, 8'h11, 8'hFF, 1, 0};
    vecs[8]  = '{1, 0, 0, 8'h00, 1, 0, 0, 3, 0, 8'hFF, 8'h11, 8'hFF, 8'h11, 8'hFF, 0, 0};
    vecs[9]  = '{1, 0, 0, 8'h00, 1, 1, 0, 3, 0, 8'h00, 8'h11, 8'h00, 8'h11, 8'h00, 0, 1};
    vecs[10] = '{1, 1, 3, 8'hAA, 1, 1, 0, 3, 2, 8'hAA, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 1};
    vecs[11] = '{1, 0, 0, 8'h00, 0, 0, 1, 3, 1, 8'hAA, 8'h00, 8'hAA, 8'h00, 8'hAA, 1, 1};
    vecs[12] = '{1, 1, 1, 8'h55, 0, 1, 0, 1, 3, 8'h55, 8'hAA, 8'h00, 8'hAA, 8'hAA, 0, 0};
    vecs[13] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 3, 8'h55, 8'hA9, 8'h55, 8'hA9, 8'hA9, 0, 0};
    vecs[14] = '{1, 1, 3, 8'h00, 0, 0, 0, 0, 2, 8'h11, 8'h00, 8'h11, 8'h00, 8'hA9, 0, 0};
    vecs[15] = '{1, 0, 0, 8'h00, 0, 1, 1, 3, 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0};
    vecs[16] = '{1, 0, 0, 8'h00, 0, 0, 0, 3, 0, 8'hFF, 8'h11, 8'hFF, 8'h11, 8'hFF, 1, 0};
    vecs[17] = '{1, 1, 3, 8'h20, 0, 0, 0, 2, 1, 8'h00, 8'h55, 8'h00, 8'h55, 8'hFF, 1, 0};
    vecs[18] = '{0, 1, 0, 8'h77, 0, 1, 0, 3, 1, 8'h20, 8'h55, 8'h20, 8'h55, 8'h20, 1, 0};
    vecs[19] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 0};
    vecs[20] = '{1, 0, 0, 8'h00, 0, 0, 0, 2, 3, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 0, 0};

    // Reset held for two edges with write/push activity that must be ignored.
    apply(0, 1, 0, 8'h5A, 1, 1, 0, 0, 0); tick();
    apply(0, 1, 3, 8'h33, 0, 1, 1, 0, 0); tick();

    foreach (vecs[k]) begin
      apply(vecs[k].rst_n, vecs[k].we, vecs[k].addr, vecs[k].wd, vecs[k].inc,
            vecs[k].dec, vecs[k].clr, vecs[k].ra, vecs[k].rb);
      chk($sformatf("vec%0d rd_a", k), rd_a, vecs[k].a);
      chk($sformatf("vec%0d rd_b", k), rd_b, vecs[k].b);
      chk($sformatf("vec%0d rd_a nobyp", k), rd_a0, vecs[k].a0);
      chk($sformatf("vec%0d rd_b nobyp", k), rd_b0, vecs[k].b0);
      chk($sformatf("vec%0d sp_out", k), sp_out, vecs[k].sp);
      chk($sformatf("vec%0d sp_out nobyp", k), sp_out0, vecs[k].sp);
      chk($sformatf("vec%0d sp_ovf", k), {7'd0, sp_ovf}, {7'd0, vecs[k].ovf});
      chk($sformatf("vec%0d sp_unf", k), {7'd0, sp_unf}, {7'd0, vecs[k].unf});
      tick();
    end

    // Push sequence through zero: 02 -> 01 -> 00 -> FF with overflow on the wrap.
    apply(1, 1, 3, 8'h02, 0, 0, 0, 3, 3); tick();
    apply(1, 0, 0, 8'h00, 0, 1, 0, 3, 3);
    chk("push sp=02", sp_out, 8'h02); tick();
    apply(1, 0, 0, 8'h00, 0, 1, 0, 3, 3);
    chk("push sp=01", sp_out, 8'h01); tick();
    apply(1, 0, 0, 8'h00, 0, 1, 0, 3, 3);
    chk("push sp=00", sp_out, 8'h00);
    chk("push ovf before wrap", {7'd0, sp_ovf}, 8'h00); tick();
    apply(1, 0, 0, 8'h00, 0, 0, 0, 3, 3);
    chk("push sp=FF", sp_out, 8'hFF);
    chk("push ovf after wrap", {7'd0, sp_ovf}, 8'h01); tick();

    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 49) != 0);
      w  = ($urandom_range(0, 2) == 0);
      ad = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = 8'h00;
        1:       d = 8'hFF;
        2:       d = 8'h01;
        default: d = 8'($urandom);
      endcase
      i  = 1'($urandom_range(0, 1));
      dc = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      b  = 2'($urandom_range(0, 3));
      apply(r, w, ad, d, i, dc, c, a, b);
      chk_model(n);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sp_param.md
REGFILE_SP_PARAM -- requirements
Module: regfile_sp_param

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, register and data width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 2, address width; register count NREGS = 2**ADDR_W.
REQ-003 The block SHALL provide parameter SP_IDX, default NREGS-1, index of the stack-pointer register.
REQ-004 The block SHALL provide parameter SP_RESET, default all-ones, reset value of the stack-pointer register.
REQ-005 The block SHALL provide parameter BYPASS, default 1, which enables write-to-read forwarding when 1.
REQ-006 The block SHALL have one clock; reset is synchronous and active-low.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 we  input  1  write enable for port W.
REQ-010 rw_addr  input  ADDR_W  write address.
REQ-011 wd  input  DATA_W  write data.
REQ-012 inc_sp  input  1  increment SP by 1 (pop).
REQ-013 dec_sp  input  1  decrement SP by 1 (push).
REQ-014 clr_flags  input  1  clears sticky stack flags.
REQ-015 ra_addr, rb_addr  input  ADDR_W each  read addresses, ports A and B.
REQ-016 rd_a, rd_b  output  DATA_W each  read data, ports A and B.
REQ-017 sp_out  output  DATA_W  current SP register contents.
REQ-018 sp_ovf  output  1  sticky stack overflow flag (push wrapped).
REQ-019 sp_unf  output  1  sticky stack underflow flag (pop wrapped).

Function
REQ-020 Reads SHALL be combinational: rd_a = reg[ra_addr], rd_b = reg[rb_addr], sp_out = reg[SP_IDX], with no clock latency.
REQ-021 With BYPASS=1, when we=1 and rw_addr equals a read address, that port SHALL return wd in the same cycle; with BYPASS=0 it SHALL return the stored value.
REQ-022 When we=1, reg[rw_addr] SHALL take wd at the next rising edge.
REQ-023 SP update priority SHALL be: we with rw_addr=SP_IDX, then dec_sp, then inc_sp, then hold.
REQ-024 When we=1 and rw_addr=SP_IDX, inc_sp and dec_sp SHALL be ignored and no flag SHALL be set.
REQ-025 When dec_sp and inc_sp are both 1 without an SP write, SP SHALL decrement only.
REQ-026 When we=1 targets a non-SP register, inc_sp/dec_sp SHALL still apply to SP in the same cycle.
REQ-027 SP arithmetic SHALL be modulo 2**DATA_W.
REQ-028 A decrement applied at SP=0 SHALL wrap SP to all-ones and set sp_ovf.
REQ-029 An increment applied at SP=all-ones SHALL wrap SP to 0 and set sp_unf.
REQ-030 sp_ovf and sp_unf SHALL remain 1 until reset or clr_flags=1.
REQ-031 When clr_flags=1 and a wrap occur in the same cycle, the flag SHALL set, because set wins over clear.
REQ-032 Bypass SHALL forward wd only and SHALL NOT forward inc/dec results.

Reset
REQ-033 When rst_n=0 at a rising edge, every register except SP SHALL become 0.
REQ-034 On the same reset edge, reg[SP_IDX] SHALL become SP_RESET.
REQ-035 On the same reset edge, sp_ovf and sp_unf SHALL become 0.
REQ-036 Reset SHALL override we, inc_sp, dec_sp and clr_flags.
REQ-037 Reads SHALL remain combinational during reset and reflect the stored contents.

Verification (DATA_W=8, ADDR_W=2, SP_IDX=3, SP_RESET=FF, BYPASS=1)
REQ-038 Reset, then read all registers -> R0..R2=00, R3=FF, sp_ovf=sp_unf=0.
REQ-039 we=1, rw_addr=0, wd=11 with ra_addr=0 -> rd_a=11 in the same cycle via bypass; R0=11 after the edge. Repeat with BYPASS=0 -> rd_a=00 until the edge.
REQ-040 Write R3=01, then dec_sp twice -> SP=00, then FF with sp_ovf=1. Then clr_flags -> sp_ovf=0.
REQ-041 SP=FF, inc_sp -> SP=00 with sp_unf=1; inc_sp+dec_sp together -> SP=FF (decrement wins).
REQ-042 we=1, rw_addr=3, wd=AA with inc_sp=dec_sp=1 -> SP=AA and no flag change. Then we=1, rw_addr=1, wd=55 with dec_sp=1 -> R1=55 and SP=A9.
REQ-043 With sp_ovf=1 and SP=20, assert rst_n=0 while dec_sp=1 -> SP=FF and sp_ovf=0. An idle cycle afterwards -> all state unchanged.
